// File: rtl/cache_refill_axi.sv
// Line-refill engine: fetches one cache line with a single AXI4 INCR read burst
// and presents the assembled line, with an error flag, back to the cache.
module cache_refill_axi #(
    parameter int          BLOCK_SIZE = 16,
    parameter logic [5:0]  REFILL_ID  = 6'h20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    output logic                    fill_valid,
    input  logic                    fill_ready,
    output logic [31:0]             fill_addr,
    output logic [BLOCK_SIZE*8-1:0] fill_data,
    output logic                    fill_err,
    output logic [5:0]              o_ar_id,
    output logic [31:0]             o_ar_addr,
    output logic [7:0]              o_ar_len,
    output logic [2:0]              o_ar_size,
    output logic [1:0]              o_ar_burst,
    output logic                    o_ar_lock,
    output logic [3:0]              o_ar_cache,
    output logic [2:0]              o_ar_prot,
    output logic [3:0]              o_ar_region,
    output logic [3:0]              o_ar_qos,
    output logic                    o_ar_valid,
    input  logic                    i_ar_ready,
    input  logic [5:0]              i_r_id,
    input  logic [63:0]             i_r_data,
    input  logic [1:0]              i_r_resp,
    input  logic                    i_r_last,
    input  logic                    i_r_valid,
    output logic                    o_r_ready
);

    localparam int BEATS       = BLOCK_SIZE / 8;
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W      = BLOCK_SIZE * 8;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FILL} state_t;

    state_t             state;
    state_t             state_next;
    logic               rst_seen;
    logic [31:0]        line_addr;
    logic [LINE_W-1:0]  line_data;
    logic [CNT_W-1:0]   count;
    logic               err;
    logic               accept;
    logic               beat;
    logic               final_slot;

    // Burst ID is unchecked (single outstanding burst); EXOKAY vs OKAY is irrelevant.
    logic unused_inputs;
    assign unused_inputs = ^i_r_id ^ i_r_resp[0];

    assign accept     = req_valid && req_ready;
    assign beat       = (state == DATA) && i_r_valid;
    assign final_slot = (count == CNT_W'(BEATS - 1));

    assign o_ar_id     = REFILL_ID;
    assign o_ar_addr   = line_addr;
    assign o_ar_len    = 8'(BEATS - 1);
    assign o_ar_size   = 3'b011;
    assign o_ar_burst  = 2'b01;
    assign o_ar_lock   = 1'b0;
    assign o_ar_cache  = 4'b0011;
    assign o_ar_prot   = 3'b000;
    assign o_ar_region = 4'b0000;
    assign o_ar_qos    = 4'b0000;

    assign fill_addr = line_addr;
    assign fill_data = line_data;
    assign fill_err  = err;

    // rst_seen keeps req_ready low during reset without a path from the rst pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rst_seen <= 1'b1;
        end else begin
            state    <= state_next;
            rst_seen <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        o_ar_valid = 1'b0;
        o_r_ready  = 1'b0;
        fill_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst_seen;
                if (req_valid && !rst_seen) state_next = ADDR;
            end
            ADDR: begin
                o_ar_valid = 1'b1;
                if (i_ar_ready) state_next = DATA;
            end
            DATA: begin
                o_r_ready = 1'b1;
                if (i_r_valid && (final_slot || i_r_last)) state_next = FILL;
            end
            FILL: begin
                fill_valid = 1'b1;
                if (fill_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A LAST flag on any beat other than the final slot, or missing on it, is an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_addr <= '0;
            line_data <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                line_addr <= req_addr & ADDR_MASK;
                count     <= '0;
                err       <= 1'b0;
            end
            if (beat) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (count == CNT_W'(k)) line_data[64*k +: 64] <= i_r_data;
                end
                count <= count + 1'b1;
                err   <= err | i_r_resp[1] | (final_slot != i_r_last);
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_axi.sv
// Directed bench for cache_refill_axi with a scoreboard of expected AR addresses and fills.
module tb_cache_refill_axi;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         fill_valid;
    logic         fill_ready;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic         fill_err;
    logic [5:0]   o_ar_id;
    logic [31:0]  o_ar_addr;
    logic [7:0]   o_ar_len;
    logic [2:0]   o_ar_size;
    logic [1:0]   o_ar_burst;
    logic         o_ar_lock;
    logic [3:0]   o_ar_cache;
    logic [2:0]   o_ar_prot;
    logic [3:0]   o_ar_region;
    logic [3:0]   o_ar_qos;
    logic         o_ar_valid;
    logic         i_ar_ready;
    logic [5:0]   i_r_id;
    logic [63:0]  i_r_data;
    logic [1:0]   i_r_resp;
    logic         i_r_last;
    logic         i_r_valid;
    logic         o_r_ready;

    always #5 clk = ~clk;

    cache_refill_axi #(.BLOCK_SIZE(16), .REFILL_ID(6'h20)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .fill_data(fill_data), .fill_err(fill_err),
        .o_ar_id(o_ar_id), .o_ar_addr(o_ar_addr), .o_ar_len(o_ar_len),
        .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst), .o_ar_lock(o_ar_lock),
        .o_ar_cache(o_ar_cache), .o_ar_prot(o_ar_prot), .o_ar_region(o_ar_region),
        .o_ar_qos(o_ar_qos), .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready),
        .i_r_id(i_r_id), .i_r_data(i_r_data), .i_r_resp(i_r_resp),
        .i_r_last(i_r_last), .i_r_valid(i_r_valid), .o_r_ready(o_r_ready)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         err;
    } fill_t;

    fill_t        fill_q[$];
    logic [31:0]  ar_q[$];
    fill_t        exp_fill;
    logic [127:0] stale_line = '0;
    int           checks = 0;
    int           failures = 0;
    int           fills = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are sampled mid-cycle, where inputs and registered outputs are settled.
    always @(negedge clk) begin
        if (!rst && o_ar_valid && i_ar_ready) begin
            check("ar_expected", 128'(ar_q.size() != 0), 128'(1));
            if (ar_q.size() != 0) check("ar_addr", 128'(o_ar_addr), 128'(ar_q.pop_front()));
        end
        if (!rst && fill_valid && fill_ready) begin
            fills++;
            check("fill_expected", 128'(fill_q.size() != 0), 128'(1));
            if (fill_q.size() != 0) begin
                exp_fill = fill_q.pop_front();
                check("fill_addr", 128'(fill_addr), 128'(exp_fill.addr));
                check("fill_data", fill_data, exp_fill.data);
                check("fill_err", 128'(fill_err), 128'(exp_fill.err));
            end
        end
    end

    // mode: 0 = normal, 1 = LAST on beat 0, 2 = no LAST on the final beat
    task automatic refill(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [1:0] resp0, input int mode, input int ar_wait,
                          input int gap, input int fill_wait,
                          input bit hold_next, input logic [31:0] next_addr);
        logic [127:0] exp_line;
        logic         exp_err;
        logic [31:0]  line;
        int           n;
        line     = addr & 32'hFFFF_FFF0;
        exp_line = (mode == 1) ? {stale_line[127:64], d0} : {d1, d0};
        exp_err  = resp0[1] || (mode != 0);
        ar_q.push_back(line);
        fill_q.push_back('{line, exp_line, exp_err});
        stale_line = exp_line;

        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("req_ready_wait", 128'(req_ready), 128'(1));
        step();
        if (hold_next) req_addr = next_addr;
        else req_valid = 1'b0;

        check("ar_valid", 128'(o_ar_valid), 128'(1));
        check("req_ready_busy", 128'(req_ready), 128'(0));
        check("ar_addr_now", 128'(o_ar_addr), 128'(line));
        check("ar_len", 128'(o_ar_len), 128'(1));
        check("ar_size", 128'(o_ar_size), 128'(3));
        check("ar_burst", 128'(o_ar_burst), 128'(1));
        check("ar_id", 128'(o_ar_id), 128'(6'h20));
        for (int i = 0; i < ar_wait; i++) begin
            step();
            check("ar_valid_hold", 128'(o_ar_valid), 128'(1));
            check("ar_addr_hold", 128'(o_ar_addr), 128'(line));
            check("ar_len_hold", 128'(o_ar_len), 128'(1));
            check("r_ready_in_addr", 128'(o_r_ready), 128'(0));
        end
        i_ar_ready = 1'b1;
        step();
        i_ar_ready = 1'b0;
        check("r_ready_data", 128'(o_r_ready), 128'(1));
        check("ar_valid_drop", 128'(o_ar_valid), 128'(0));

        i_r_valid = 1'b1;
        i_r_data  = d0;
        i_r_resp  = resp0;
        i_r_last  = (mode == 1);
        step();
        i_r_valid = 1'b0;
        i_r_last  = 1'b0;
        i_r_resp  = 2'b00;
        if (mode != 1) begin
            check("fill_valid_early", 128'(fill_valid), 128'(0));
            for (int i = 0; i < gap; i++) begin
                step();
                check("r_ready_gap", 128'(o_r_ready), 128'(1));
                check("fill_valid_gap", 128'(fill_valid), 128'(0));
            end
            i_r_valid = 1'b1;
            i_r_data  = d1;
            i_r_last  = (mode == 0);
            step();
            i_r_valid = 1'b0;
            i_r_last  = 1'b0;
        end
        check("fill_valid", 128'(fill_valid), 128'(1));
        check("r_ready_fill", 128'(o_r_ready), 128'(0));
        check("fill_err_now", 128'(fill_err), 128'(exp_err));

        for (int i = 0; i < fill_wait; i++) begin
            if (mode == 1) begin
                i_r_valid = 1'b1;
                i_r_data  = 64'hDEAD_BEEF_DEAD_BEEF;
                i_r_last  = 1'b1;
            end
            step();
            check("fill_valid_hold", 128'(fill_valid), 128'(1));
            check("fill_data_hold", fill_data, exp_line);
            check("req_ready_fill", 128'(req_ready), 128'(0));
        end
        i_r_valid  = 1'b0;
        i_r_last   = 1'b0;
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;
        check("fill_valid_done", 128'(fill_valid), 128'(0));
        check("req_ready_after", 128'(req_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; fill_ready = 1'b0; i_ar_ready = 1'b0;
        i_r_id = 6'h20; i_r_data = '0; i_r_resp = 2'b00; i_r_last = 1'b0; i_r_valid = 1'b0;
        step();
        step();
        check("rst_ar_valid", 128'(o_ar_valid), 128'(0));
        check("rst_r_ready", 128'(o_r_ready), 128'(0));
        check("rst_fill_valid", 128'(fill_valid), 128'(0));
        check("rst_fill_err", 128'(fill_err), 128'(0));
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_fill_addr", 128'(fill_addr), 128'(0));
        check("rst_fill_data", fill_data, 128'(0));
        check("rst_ar_addr", 128'(o_ar_addr), 128'(0));
        check("rst_ar_cache", 128'(o_ar_cache), 128'(4'b0011));
        check("rst_ar_id", 128'(o_ar_id), 128'(6'h20));
        rst = 1'b0;
        step();
        check("req_ready_idle", 128'(req_ready), 128'(1));

        refill(32'h0000_1238, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 2'b00, 0, 0, 0, 0, 1'b0, '0);
        refill(32'h0000_1238, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 2'b00, 0, 3, 2, 5, 1'b0, '0);
        refill(32'h0000_2004, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 2'b10, 0, 0, 0, 0, 1'b0, '0);
        refill(32'h0000_300F, 64'h3333_4444_5555_6666, 64'h7777_7777_7777_7777, 2'b00, 1, 0, 0, 2, 1'b0, '0);
        refill(32'h0000_4010, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b00, 2, 1, 0, 0, 1'b0, '0);
        refill(32'h0000_5000, 64'h5555_0000_0000_0005, 64'h6666_0000_0000_0006, 2'b00, 0, 0, 1, 1, 1'b1, 32'hABCD_EF18);
        refill(32'hABCD_EF18, 64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0002, 2'b00, 0, 0, 0, 0, 1'b0, '0);

        ar_q.push_back(32'h0000_5670);
        req_valid = 1'b1;
        req_addr  = 32'h0000_5674;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("rst_test_req_ready", 128'(req_ready), 128'(1));
        step();
        req_valid  = 1'b0;
        i_ar_ready = 1'b1;
        step();
        i_ar_ready = 1'b0;
        i_r_valid  = 1'b1;
        i_r_data   = 64'h9999_9999_9999_9999;
        i_r_resp   = 2'b10;
        step();
        i_r_valid = 1'b0;
        i_r_resp  = 2'b00;
        rst = 1'b1;
        step();
        check("mid_rst_ar_valid", 128'(o_ar_valid), 128'(0));
        check("mid_rst_r_ready", 128'(o_r_ready), 128'(0));
        check("mid_rst_fill_valid", 128'(fill_valid), 128'(0));
        check("mid_rst_fill_err", 128'(fill_err), 128'(0));
        check("mid_rst_req_ready", 128'(req_ready), 128'(0));
        check("mid_rst_fill_data", fill_data, 128'(0));
        rst = 1'b0;
        stale_line = '0;
        step();
        check("post_rst_req_ready", 128'(req_ready), 128'(1));
        refill(32'h0000_6000, 64'h6000_0000_0000_0000, 64'h6000_0000_0000_0008, 2'b00, 0, 0, 0, 0, 1'b0, '0);

        step();
        check("ar_queue_empty", 128'(ar_q.size()), 128'(0));
        check("fill_queue_empty", 128'(fill_q.size()), 128'(0));
        check("fill_count", 128'(fills), 128'(8));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
